// File: rtl/prog_seq_pkg.sv
// Shared types and defaults for the instruction-fetch run controller.
package prog_seq_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;

  localparam int PROG_SEL_MAX = 2;

  localparam logic [9:0] START_ADDR0_DEF = 10'd0;
  localparam logic [9:0] START_ADDR1_DEF = 10'd128;
  localparam logic [9:0] START_ADDR2_DEF = 10'd256;

  function automatic logic prog_sel_valid(input logic [1:0] sel);
    return int'(sel) <= PROG_SEL_MAX;
  endfunction

endpackage

// File: rtl/prog_sequencer_cycle_counter.sv
// Run-length counter: synchronous clear, count enable, terminal-count flag.
module seq_cycle_counter #(
  parameter int            CW         = 16,
  parameter logic [CW-1:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          tc
);

  // tc marks the last permitted cycle, so count tops out at MAX_CYCLES and never wraps
  assign tc = (count == MAX_CYCLES - CW'(1));

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/prog_sequencer.sv
// Run controller between the start/done handshake and the fetch unit.
// state | meaning
// IDLE  | fetch frozen, waiting for Start
// LOAD  | one cycle, fetch unit loads Start_addr
// RUN   | program executing, cycles counted
// DONE  | run finished (halt, timeout or bad Prog_sel), waiting for Start
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int            AW          = 10,
  parameter int            CW          = 16,
  parameter logic [CW-1:0] MAX_CYCLES  = 16'hFFFF,
  parameter logic [AW-1:0] START_ADDR0 = AW'(START_ADDR0_DEF),
  parameter logic [AW-1:0] START_ADDR1 = AW'(START_ADDR1_DEF),
  parameter logic [AW-1:0] START_ADDR2 = AW'(START_ADDR2_DEF)
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          Start,
  input  logic [1:0]    Prog_sel,
  input  logic          Halt_instr,
  input  logic          Stall,
  output logic          Fetch_init,
  output logic          Fetch_halt,
  output logic [AW-1:0] Start_addr,
  output logic          Busy,
  output logic          Done,
  output logic          Timeout,
  output logic          Err,
  output logic [CW-1:0] Cycle_count
);

  seq_state_t    state_q, state_d;
  logic          start_req;
  logic          sel_ok;
  logic          run_end;
  logic          tc;
  logic [AW-1:0] sel_addr;

  seq_cycle_counter #(
    .CW         (CW),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_cnt (
    .CLK     (CLK),
    .Reset_n (Reset_n),
    .clr     (state_q == LOAD),
    .en      (state_q == RUN),
    .count   (Cycle_count),
    .tc      (tc)
  );

  assign sel_ok    = prog_sel_valid(Prog_sel);
  assign start_req = Start && ((state_q == IDLE) || (state_q == DONE));
  assign run_end   = (state_q == RUN) && (Halt_instr || tc);

  always_comb begin
    case (Prog_sel)
      2'd0:    sel_addr = START_ADDR0;
      2'd1:    sel_addr = START_ADDR1;
      default: sel_addr = START_ADDR2;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (Start) state_d = sel_ok ? LOAD : DONE;
      LOAD:       state_d = RUN;
      RUN:        if (Halt_instr || tc) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Status registers; halt beats timeout when both land in the same cycle
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      Start_addr <= '0;
      Err        <= 1'b0;
      Timeout    <= 1'b0;
    end else if (start_req) begin
      Err     <= !sel_ok;
      Timeout <= 1'b0;
      if (sel_ok) Start_addr <= sel_addr;
    end else if (run_end) begin
      Timeout <= !Halt_instr;
    end
  end

  assign Fetch_init = (state_q == LOAD);
  assign Busy       = (state_q == LOAD) || (state_q == RUN);
  assign Done       = (state_q == DONE);
  assign Fetch_halt = (state_q == RUN) ? (Stall | Halt_instr) : 1'b1;

endmodule

// File: tb/tb_prog_sequencer.sv
// Randomized self-checking bench for prog_sequencer against a run-level model.
module tb_prog_sequencer;

  localparam int AW   = 10;
  localparam int CW   = 16;
  localparam int MAXC = 8;

  logic          CLK = 1'b0;
  logic          Reset_n = 1'b0;
  logic          Start = 1'b0;
  logic [1:0]    Prog_sel = 2'd0;
  logic          Halt_instr = 1'b0;
  logic          Stall = 1'b0;
  logic          Fetch_init, Fetch_halt, Busy, Done, Timeout, Err;
  logic [AW-1:0] Start_addr;
  logic [CW-1:0] Cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  int last_addr = 0;
  int last_count = 0;

  prog_sequencer #(
    .AW         (AW),
    .CW         (CW),
    .MAX_CYCLES (16'(MAXC))
  ) dut (
    .CLK         (CLK),
    .Reset_n     (Reset_n),
    .Start       (Start),
    .Prog_sel    (Prog_sel),
    .Halt_instr  (Halt_instr),
    .Stall       (Stall),
    .Fetch_init  (Fetch_init),
    .Fetch_halt  (Fetch_halt),
    .Start_addr  (Start_addr),
    .Busy        (Busy),
    .Done        (Done),
    .Timeout     (Timeout),
    .Err         (Err),
    .Cycle_count (Cycle_count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int addr_of(input int sel);
    return sel * 128;
  endfunction

  task automatic check_reset_values(input string where);
    chk({where, " fetch_init"}, int'(Fetch_init), 0);
    chk({where, " fetch_halt"}, int'(Fetch_halt), 1);
    chk({where, " start_addr"}, int'(Start_addr), 0);
    chk({where, " busy"}, int'(Busy), 0);
    chk({where, " done"}, int'(Done), 0);
    chk({where, " timeout"}, int'(Timeout), 0);
    chk({where, " err"}, int'(Err), 0);
    chk({where, " count"}, int'(Cycle_count), 0);
  endtask

  // One start request and, for a valid program, the whole run to DONE.
  // halt_at > MAXC means no halt instruction is ever seen.
  task automatic do_run(input int sel, input int halt_at, input bit poke);
    int  end_cyc;
    bit  exp_to;
    bit  s, h;
    @(posedge CLK); #1;
    Start = 1'b1; Prog_sel = 2'(sel);
    @(posedge CLK); #1;
    Start = 1'b0; Prog_sel = 2'($urandom_range(0, 3));
    @(negedge CLK);
    if (sel == 3) begin
      chk("bad_sel done", int'(Done), 1);
      chk("bad_sel err", int'(Err), 1);
      chk("bad_sel init", int'(Fetch_init), 0);
      chk("bad_sel busy", int'(Busy), 0);
      chk("bad_sel addr", int'(Start_addr), last_addr);
      chk("bad_sel timeout", int'(Timeout), 0);
      chk("bad_sel count", int'(Cycle_count), last_count);
      return;
    end
    last_addr = addr_of(sel);
    chk("load init", int'(Fetch_init), 1);
    chk("load addr", int'(Start_addr), last_addr);
    chk("load busy", int'(Busy), 1);
    chk("load fetch_halt", int'(Fetch_halt), 1);
    end_cyc = (halt_at < MAXC) ? halt_at : MAXC;
    exp_to  = (halt_at > MAXC);
    for (int k = 1; k <= end_cyc; k++) begin
      @(posedge CLK); #1;
      s = 1'($urandom_range(0, 1));
      h = (k == halt_at);
      Stall = s; Halt_instr = h;
      Start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      Prog_sel = 2'($urandom_range(0, 3));
      @(negedge CLK);
      chk("run busy", int'(Busy), 1);
      chk("run init", int'(Fetch_init), 0);
      chk("run done", int'(Done), 0);
      chk("run fetch_halt", int'(Fetch_halt), int'(s | h));
      chk("run count", int'(Cycle_count), k - 1);
    end
    @(posedge CLK); #1;
    Stall = 1'b0; Halt_instr = 1'b0; Start = 1'b0;
    @(negedge CLK);
    last_count = end_cyc;
    chk("end done", int'(Done), 1);
    chk("end busy", int'(Busy), 0);
    chk("end count", int'(Cycle_count), end_cyc);
    chk("end timeout", int'(Timeout), int'(exp_to));
    chk("end err", int'(Err), 0);
    chk("end fetch_halt", int'(Fetch_halt), 1);
  endtask

  initial begin
    #12;
    check_reset_values("reset");
    @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);
    check_reset_values("post_reset");

    do_run(1, 5, 1'b0);
    do_run(0, 100, 1'b0);
    do_run(2, MAXC, 1'b0);
    do_run(3, 1, 1'b0);
    do_run(0, 1, 1'b1);
    do_run(3, 1, 1'b0);

    repeat (3) @(negedge CLK);
    chk("hold done", int'(Done), 1);
    chk("hold count", int'(Cycle_count), last_count);

    for (int i = 0; i < 40; i++) begin
      do_run(int'($urandom_range(0, 3)), int'($urandom_range(1, MAXC + 2)), 1'($urandom_range(0, 1)));
    end

    // reset in the middle of a run
    @(posedge CLK); #1; Start = 1'b1; Prog_sel = 2'd2;
    @(posedge CLK); #1; Start = 1'b0;
    repeat (3) @(posedge CLK);
    #1; Stall = 1'b1;
    #2; Reset_n = 1'b0;
    #1;
    check_reset_values("async_reset");
    last_addr = 0;
    last_count = 0;
    @(negedge CLK);
    Stall = 1'b0;
    Reset_n = 1'b1;
    do_run(1, 3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
